// File: rtl/vmicro16_apb_gpio_ctrl.sv
// vmicro16_apb_gpio_ctrl: APB GPIO bank with set/clr/toggle, synchronised inputs and rising-edge irq
module vmicro16_apb_gpio_ctrl #(
   parameter int PINS = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter logic [PINS-1:0] OUT_RESET = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] S_PADDR,
   input  logic                  S_PWRITE,
   input  logic                  S_PSELx,
   input  logic                  S_PENABLE,
   input  logic [DATA_WIDTH-1:0] S_PWDATA,
   output logic [DATA_WIDTH-1:0] S_PRDATA,
   output logic                  S_PREADY,
   output logic [PINS-1:0]       gpio_out,
   input  logic [PINS-1:0]       gpio_in,
   output logic                  irq
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   localparam logic [ADDR_WIDTH-1:0] A_OUT = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_SET = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_CLR = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_TGL = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_IN  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_EDG = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] A_IEN = ADDR_WIDTH'(6);
   state_t state_q, state_d;
   logic [PINS-1:0] out_q, out_d, sync1_q, sync2_q, prev_q;
   logic [PINS-1:0] edge_q, edge_d, irq_en_q, irq_en_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [PINS-1:0] wd, w1c, rd;
   logic wr;
   always_comb begin
      state_d  = (state_q == SETUP) ? ACCESS : (S_PSELx && !S_PENABLE) ? SETUP : IDLE;
      wr       = (state_q == ACCESS) && S_PSELx && S_PWRITE;
      wd       = S_PWDATA[PINS-1:0];
      out_d    = !wr ? out_q :
                 (S_PADDR == A_OUT) ? wd :
                 (S_PADDR == A_SET) ? (out_q | wd) :
                 (S_PADDR == A_CLR) ? (out_q & ~wd) :
                 (S_PADDR == A_TGL) ? (out_q ^ wd) : out_q;
      irq_en_d = (wr && S_PADDR == A_IEN) ? wd : irq_en_q;
      w1c      = (wr && S_PADDR == A_EDG) ? wd : '0;
      // a rise in the same cycle as its W1C must survive
      edge_d   = (edge_q & ~w1c) | (sync2_q & ~prev_q);
      rd       = (S_PADDR == A_OUT) ? out_q :
                 (S_PADDR == A_IN)  ? sync2_q :
                 (S_PADDR == A_EDG) ? edge_q :
                 (S_PADDR == A_IEN) ? irq_en_q : '0;
      prdata_d = (state_q == SETUP) ? DATA_WIDTH'(rd) : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         out_q    <= OUT_RESET;
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         edge_q   <= '0;
         irq_en_q <= '0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         sync1_q  <= gpio_in;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         edge_q   <= edge_d;
         irq_en_q <= irq_en_d;
         prdata_q <= prdata_d;
      end
   end
   assign S_PREADY = (state_q == ACCESS);
   assign S_PRDATA = prdata_q;
   assign gpio_out = out_q;
   assign irq      = |(edge_q & irq_en_q);
endmodule

// File: tb/tb_vmicro16_apb_gpio_ctrl.sv
// tb_vmicro16_apb_gpio_ctrl: directed checks of register map, edge capture, irq and reset abort
module tb_vmicro16_apb_gpio_ctrl;
   logic clk = 0, reset = 1;
   logic [2:0] S_PADDR = '0;
   logic S_PWRITE = 0, S_PSELx = 0, S_PENABLE = 0;
   logic [15:0] S_PWDATA = '0, S_PRDATA, gpio_out, gpio_in = '0, r;
   logic S_PREADY, irq;
   int checks = 0, errors = 0;

   vmicro16_apb_gpio_ctrl dut (
      .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
      .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
      .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .gpio_out(gpio_out),
      .gpio_in(gpio_in), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // starts driving immediately; caller must be just after a rising edge
   task automatic xfer(input logic w, input logic [2:0] a, input logic [15:0] d, output logic [15:0] rdata);
      S_PSELx = 1; S_PENABLE = 0; S_PWRITE = w; S_PADDR = a; S_PWDATA = d;
      tick();
      S_PENABLE = 1;
      check("ready_setup", S_PREADY, 0);
      tick();
      check("ready_access", S_PREADY, 1);
      rdata = S_PRDATA;
      tick();
      S_PSELx = 0; S_PENABLE = 0;
      check("ready_idle", S_PREADY, 0);
      check("prdata_idle", S_PRDATA, 0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      logic [15:0] dummy;
      xfer(1, a, d, dummy);
   endtask

   task automatic rdchk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      logic [15:0] v;
      xfer(0, a, 16'h0, v);
      check(tag, v, exp);
   endtask

   initial begin
      repeat (4) @(posedge clk);
      #1 reset = 0;
      check("rst_gpio_out", gpio_out, 16'h0);
      check("rst_irq", irq, 0);
      check("rst_prdata", S_PRDATA, 16'h0);
      check("rst_pready", S_PREADY, 0);
      tick();
      check("idle_pready", S_PREADY, 0);
      check("idle_prdata", S_PRDATA, 16'h0);

      wr(3'd0, 16'h7008);
      check("out_write", gpio_out, 16'h7008);
      rdchk("out_read", 3'd0, 16'h7008);
      wr(3'd1, 16'h0003);
      check("set", gpio_out, 16'h700B);
      wr(3'd2, 16'h7000);
      check("clr", gpio_out, 16'h000B);
      wr(3'd3, 16'hFFFF);
      check("tgl", gpio_out, 16'hFFF4);
      rdchk("set_read0", 3'd1, 16'h0000);
      rdchk("rsvd_read0", 3'd7, 16'h0000);
      wr(3'd4, 16'hAAAA);
      rdchk("out_after_in_wr", 3'd0, 16'hFFF4);

      wr(3'd6, 16'h0001);
      rdchk("irq_en_read", 3'd6, 16'h0001);
      gpio_in = 16'h0001;
      tick();
      check("irq_k", irq, 0);
      tick();
      check("irq_k1", irq, 0);
      tick();
      check("irq_k2", irq, 1);
      rdchk("in_read", 3'd4, 16'h0001);
      rdchk("edge_read", 3'd5, 16'h0001);
      wr(3'd5, 16'h0001);
      check("irq_w1c", irq, 0);
      repeat (4) tick();
      check("irq_held_high", irq, 0);
      rdchk("edge_held_high", 3'd5, 16'h0000);

      gpio_in = 16'h0000;
      repeat (4) tick();
      rdchk("edge_falling", 3'd5, 16'h0000);
      rdchk("in_low", 3'd4, 16'h0000);

      gpio_in = 16'h0001;
      repeat (4) tick();
      check("irq_rerise", irq, 1);
      gpio_in = 16'h0000;
      repeat (4) tick();
      gpio_in = 16'h0001;
      wr(3'd5, 16'h0001);
      rdchk("edge_set_wins", 3'd5, 16'h0001);
      check("irq_set_wins", irq, 1);
      wr(3'd6, 16'h0000);
      check("irq_en_cleared", irq, 0);
      wr(3'd5, 16'h0001);

      gpio_in = 16'h0011;
      repeat (4) tick();
      rdchk("edge_bit4", 3'd5, 16'h0010);
      check("irq_bit4_masked", irq, 0);

      S_PSELx = 1; S_PENABLE = 0; S_PWRITE = 1; S_PADDR = 3'd0; S_PWDATA = 16'h1234;
      tick();
      S_PENABLE = 1;
      tick();
      check("abort_access", S_PREADY, 1);
      reset = 1;
      tick();
      check("abort_gpio_out", gpio_out, 16'h0000);
      check("abort_pready", S_PREADY, 0);
      check("abort_prdata", S_PRDATA, 16'h0000);
      S_PSELx = 0; S_PENABLE = 0; reset = 0;
      tick();
      check("abort_gpio_after", gpio_out, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vmicro16_apb_gpio_ctrl.md
Name: vmicro16_apb_gpio_ctrl

Overview:
APB slave GPIO controller that drives the SoC's gpio1 pin bank and samples an input bank. It sits between the APB interconnect and the gpio1 pins; core software writes results, such as the summation result, to it. Provides atomic set/clear/toggle writes, a 2-flop input synchroniser, and a rising-edge interrupt status register.

Parameters:
PINS, 16, number of GPIO output and input pins; must be ≤ DATA_WIDTH.
DATA_WIDTH, 16, APB data width.
ADDR_WIDTH, 3, word-address bits decoded from S_PADDR.
OUT_RESET, 0, reset value of the output register.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
S_PADDR  in  ADDR_WIDTH  register word address
S_PWRITE  in  1  1 = write, 0 = read
S_PSELx  in  1  slave select
S_PENABLE  in  1  APB access phase
S_PWDATA  in  DATA_WIDTH  write data
S_PRDATA  out  DATA_WIDTH  read data, valid while S_PREADY is high
S_PREADY  out  1  transfer complete
gpio_out  out  PINS  output pin register
gpio_in  in  PINS  asynchronous input pins
irq  out  1  level interrupt

Behaviour:
- Register map (word address): 0 OUT RW; 1 SET WO; 2 CLR WO; 3 TGL WO; 4 IN RO; 5 EDGE R/W1C; 6 IRQ_EN RW; 7 reserved (reads 0).
- Reset (synchronous, clocked): out_reg=OUT_RESET; sync1, sync2, prev, edge_stat and irq_en = 0.
- Consequence of reset: gpio_out=OUT_RESET, irq=0, S_PRDATA=0, S_PREADY=0.
- Reset has priority over any in-flight transfer. An access phase coincident with reset is discarded.
- APB FSM has three states: IDLE, SETUP and ACCESS.
  - IDLE→SETUP when S_PSELx & !S_PENABLE.
  - SETUP→ACCESS next cycle.
  - In ACCESS, S_PREADY=1 for exactly one cycle (one wait state), then return to IDLE. If S_PSELx is still asserted with !S_PENABLE, go directly to SETUP instead.
  - S_PREADY=0 in all other states.
- A write commits on the clock edge that ends the ACCESS cycle. gpio_out shows the new value from the next cycle.
  - OUT: out_reg := wdata.
  - SET: out_reg |= wdata.
  - CLR: out_reg &= ~wdata.
  - TGL: out_reg ^= wdata.
  - IRQ_EN: irq_en := wdata.
  - EDGE: clears each bit where wdata is 1.
  - Writes to IN or reserved addresses are ignored.
- Reads: S_PRDATA is registered on entry to ACCESS from the addressed register. It is 0 outside ACCESS. SET, CLR and TGL read back 0. Unused high bits (≥PINS) read 0 and are ignored on write.
- Input path:
  - sync1<=gpio_in; sync2<=sync1; prev<=sync2.
  - IN reads sync2.
  - rise = sync2 & ~prev.
  - edge_stat <= (edge_stat & ~w1c_mask) | rise. If set and clear hit the same bit in the same cycle, set wins.
- A gpio_in rise that is stable before edge k appears in IN after edge k+1. EDGE and irq assert after edge k+2.
- irq = |(edge_stat & irq_en), combinational from registers. It is level-held until EDGE is cleared or IRQ_EN is cleared.
- Falling edges never set EDGE. A pin held high sets EDGE once only.
- Back-to-back transfers are supported: SETUP can follow ACCESS immediately.

Test Plan:
- Reset held 4 clocks, then write OUT=0x7008 → gpio_out==0x7008 one cycle after S_PREADY; read OUT returns 0x7008.
- From 0x7008: SET 0x0003 → 0x700B; CLR 0x7000 → 0x000B; TGL 0xFFFF → 0xFFF4; a read of SET returns 0x0000.
- Every transfer: S_PREADY is high for exactly one cycle, on the second cycle after S_PSELx rises. An idle bus gives S_PREADY=0 and S_PRDATA=0.
- IRQ_EN=0x0001, gpio_in 0→0x0001 before edge k → IN reads 0x0001 after k+1; EDGE=0x0001 and irq=1 after k+2. Write EDGE=0x0001 → irq=0. gpio_in held high → irq stays 0.
- Rise on bit 0 lands on the same edge as a W1C of bit 0 → EDGE bit 0 remains 1. Rise on bit 4 with IRQ_EN bit 4=0 → EDGE=0x0010, irq=0.
- Reset asserted mid-ACCESS of a write OUT=0x1234 → gpio_out==OUT_RESET and S_PREADY=0 after the reset edge; the write is not applied.
